mod_n_counter_gen: RTL and testbench

- Generalised up/down modulo counter; successor to the fixed-modulus, fixed-step mod-N counter FSM.
- Adds run-time modulus, programmable step, parallel load, wrap or saturate mode, and a terminal-count pulse.
- Used as a configurable timebase/index generator beside datapath blocks; single clock domain.

---
 rtl/mod_n_counter_gen.sv | 194 +++++++++++++++++++
 tb/tb_mod_n_counter_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_counter_gen.sv
// Up/down modulo counter with a run-time modulus and a programmable step.
// It supports parallel load, wrap or saturate mode, and a registered terminal-count pulse.
module mod_n_counter_gen #(
  parameter int WIDTH       = 8,
  parameter int STEP_W      = 4,
  parameter bit SAT_DEFAULT = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_up_down,
  input  logic              i_mode_sat,
  input  logic [WIDTH-1:0]  i_mod,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  output logic [WIDTH-1:0]  o_Q,
  output logic              o_tc,
  output logic [1:0]        o_state
);

  localparam int XW = WIDTH + 1;
  localparam logic [WIDTH-1:0] OneW = WIDTH'(1);

  typedef logic [XW-1:0] ext_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10,
    ST_SAT  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             sat_dir_q, sat_dir_d;

  ext_t             m_ext;
  ext_t             q_ext;
  ext_t             s_ext;
  ext_t             top_ext;
  ext_t             sum_ext;
  logic [WIDTH-1:0] m_top;
  logic [WIDTH-1:0] clamp_val;
  logic [WIDTH-1:0] q_hold;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_q;
  logic             step_tc;
  logic             at_bound;
  logic             range_bad;
  logic             m_is_one;
  logic             step_nz;

  function automatic logic [WIDTH-1:0] wrap_up(input ext_t q, input ext_t s, input ext_t m);
    ext_t sum;
    sum = q + s;
    if (sum >= m) return WIDTH'(sum - m);
    return WIDTH'(sum);
  endfunction

  function automatic logic [WIDTH-1:0] wrap_down(input ext_t q, input ext_t s, input ext_t m);
    if (q < s) return WIDTH'(q + m - s);
    return WIDTH'(q - s);
  endfunction

  function automatic logic [WIDTH-1:0] sat_up(input ext_t q, input ext_t s, input ext_t top);
    ext_t sum;
    sum = q + s;
    if (sum >= top) return WIDTH'(top);
    return WIDTH'(sum);
  endfunction

  function automatic logic [WIDTH-1:0] sat_down(input ext_t q, input ext_t s);
    if (q <= s) return '0;
    return WIDTH'(q - s);
  endfunction

  // A modulus of zero encodes the full 2^WIDTH range; m_top wraps to all-ones in that case.
  assign m_ext     = (i_mod == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, i_mod};
  assign m_top     = i_mod - OneW;
  assign top_ext   = {1'b0, m_top};
  assign q_ext     = {1'b0, q_q};
  assign s_ext     = ext_t'(i_step) % m_ext;
  assign sum_ext   = q_ext + s_ext;
  assign m_is_one  = (i_mod == OneW);
  assign step_nz   = |i_step;
  assign range_bad = (i_mod != '0) && (q_q >= i_mod);
  assign clamp_val = i_mode_sat ? m_top : '0;
  assign q_hold    = range_bad ? clamp_val : q_q;
  assign load_q    = ((i_mod == '0) || (i_load_val < i_mod)) ? i_load_val : m_top;

  // The candidate step result is always in the i_up_down direction.
  always_comb begin
    step_val = q_q;
    step_tc  = 1'b0;
    if (range_bad) begin
      step_val = clamp_val;
      step_tc  = 1'b0;
    end else if (i_up_down) begin
      if (i_mode_sat) begin
        step_val = sat_up(q_ext, s_ext, top_ext);
        step_tc  = (q_q != m_top) && (step_val == m_top);
      end else begin
        step_val = wrap_up(q_ext, s_ext, m_ext);
        step_tc  = (sum_ext >= m_ext) || (m_is_one && step_nz);
      end
    end else begin
      if (i_mode_sat) begin
        step_val = sat_down(q_ext, s_ext);
        step_tc  = (q_q != '0) && (step_val == '0);
      end else begin
        step_val = wrap_down(q_ext, s_ext, m_ext);
        step_tc  = (q_ext < s_ext) || (m_is_one && step_nz);
      end
    end
  end

  assign at_bound = i_up_down ? (step_val == m_top) : (step_val == '0);

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    tc_d      = 1'b0;
    sat_dir_d = sat_dir_q;
    if (i_load) begin
      q_d     = load_q;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_en) begin
            q_d     = step_val;
            tc_d    = step_tc;
            state_d = i_up_down ? ST_UP : ST_DOWN;
          end else begin
            q_d = q_hold;
          end
        end
        ST_UP, ST_DOWN: begin
          if (!i_en) begin
            q_d     = q_hold;
            state_d = ST_IDLE;
          end else begin
            q_d  = step_val;
            tc_d = step_tc;
            if (i_mode_sat && at_bound) begin
              state_d   = ST_SAT;
              sat_dir_d = i_up_down;
            end else begin
              state_d = i_up_down ? ST_UP : ST_DOWN;
            end
          end
        end
        ST_SAT: begin
          if (!i_en || !i_mode_sat) begin
            q_d     = q_hold;
            state_d = ST_IDLE;
          end else if (i_up_down != sat_dir_q) begin
            // Reversal leaves the bound by counting in the new direction on the same edge.
            q_d     = step_val;
            tc_d    = step_tc;
            state_d = i_up_down ? ST_UP : ST_DOWN;
          end else begin
            q_d = q_hold;
          end
        end
        default: begin
          q_d     = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      q_q       <= '0;
      tc_q      <= 1'b0;
      sat_dir_q <= SAT_DEFAULT;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      tc_q      <= tc_d;
      sat_dir_q <= sat_dir_d;
    end
  end

  assign o_Q     = q_q;
  assign o_tc    = tc_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_mod_n_counter_gen.sv
// Directed bench for mod_n_counter_gen: an integer reference model is checked every cycle.
// Hand-computed literal expectations are also checked after each directed step.
module tb_mod_n_counter_gen;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              up;
  logic              sat;
  logic [WIDTH-1:0]  mod;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [WIDTH-1:0]  lval;
  logic [WIDTH-1:0]  o_Q;
  logic              o_tc;
  logic [1:0]        o_state;

  int  checks = 0;
  int  errors = 0;
  bit  cmp_en = 0;

  int  mq   = 0;
  int  mtc  = 0;
  int  mst  = 0;
  bit  mdir = 0;

  int t1q[6]  = '{1, 2, 3, 4, 0, 1};
  int t1tc[6] = '{0, 0, 0, 0, 1, 0};
  int t2q[5]  = '{9, 6, 3, 0, 7};
  int t2tc[5] = '{1, 0, 0, 0, 1};
  int t3q[4]  = '{4, 7, 7, 7};
  int t3tc[4] = '{0, 1, 0, 0};
  int t3st[4] = '{1, 3, 3, 3};

  mod_n_counter_gen #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SAT_DEFAULT(1'b0)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_up_down  (up),
    .i_mode_sat (sat),
    .i_mod      (mod),
    .i_step     (step),
    .i_load     (load),
    .i_load_val (lval),
    .o_Q        (o_Q),
    .o_tc       (o_tc),
    .o_state    (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic lit(input string tag, input int q, input int tc, input int st);
    chk({tag, ".q"}, int'(o_Q), q);
    chk({tag, ".tc"}, int'(o_tc), tc);
    chk({tag, ".state"}, int'(o_state), st);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One counting step by plain modular arithmetic. States: 0 idle, 1 up, 2 down, 3 sat.
  function automatic void model_count(input int q, input bit dir_up, input bit is_sat,
                                      input int m, input int sraw,
                                      output int nq, output int ntc);
    int s;
    s = sraw % m;
    ntc = 0;
    if (q >= m) begin
      nq = is_sat ? m - 1 : 0;
    end else if (!is_sat) begin
      if (dir_up) begin
        nq  = (q + s) % m;
        ntc = (q + s >= m) ? 1 : 0;
      end else begin
        nq  = (q - s + m) % m;
        ntc = (q < s) ? 1 : 0;
      end
      if (m == 1 && sraw != 0) ntc = 1;
    end else if (dir_up) begin
      nq  = (q + s >= m - 1) ? m - 1 : q + s;
      ntc = (q != m - 1 && nq == m - 1) ? 1 : 0;
    end else begin
      nq  = (q <= s) ? 0 : q - s;
      ntc = (q != 0 && nq == 0) ? 1 : 0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    int m, hold, cq, ctc, dst;
    bit bnd;
    if (!rst_n) begin
      mq = 0; mtc = 0; mst = 0;
    end else begin
      m    = (mod == 0) ? (1 << WIDTH) : int'(mod);
      hold = (mq >= m) ? (sat ? m - 1 : 0) : mq;
      model_count(mq, up, sat, m, int'(step), cq, ctc);
      dst  = up ? 1 : 2;
      bnd  = up ? (cq == m - 1) : (cq == 0);
      mtc  = 0;
      if (load) begin
        mq  = (int'(lval) < m) ? int'(lval) : m - 1;
        mst = 0;
      end else if (mst == 0) begin
        if (en) begin mq = cq; mtc = ctc; mst = dst; end
        else mq = hold;
      end else if (mst == 1 || mst == 2) begin
        if (!en) begin mq = hold; mst = 0; end
        else begin
          mq = cq; mtc = ctc;
          if (sat && bnd) begin mst = 3; mdir = up; end
          else mst = dst;
        end
      end else begin
        if (!en || !sat) begin mq = hold; mst = 0; end
        else if (up != mdir) begin mq = cq; mtc = ctc; mst = dst; end
        else mq = hold;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model.q", int'(o_Q), mq);
      chk("model.tc", int'(o_tc), mtc);
      chk("model.state", int'(o_state), mst);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0;
    mod = '0; step = '0; load = 1'b0; lval = '0;
    repeat (2) tick();
    lit("reset", 0, 0, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    mod = 8'd5; step = 4'd1; up = 1'b1; sat = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      lit($sformatf("wrap_up%0d", i), t1q[i], t1tc[i], 1);
    end

    en = 1'b0; load = 1'b1; lval = 8'd2; mod = 8'd10; step = 4'd3; up = 1'b0;
    tick(); lit("load2", 2, 0, 0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      lit($sformatf("wrap_dn%0d", i), t2q[i], t2tc[i], 2);
    end

    en = 1'b0; load = 1'b1; lval = 8'd1; mod = 8'd8; step = 4'd3; up = 1'b1; sat = 1'b1;
    tick(); lit("load1", 1, 0, 0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      lit($sformatf("sat_up%0d", i), t3q[i], t3tc[i], t3st[i]);
    end
    up = 1'b0;
    tick(); lit("sat_rev", 4, 0, 2);

    en = 1'b1; load = 1'b1; lval = 8'd12; mod = 8'd10;
    tick(); lit("load_clamp", 9, 0, 0);
    load = 1'b0; en = 1'b0; sat = 1'b1; mod = 8'd4;
    tick(); lit("mod_shrink", 3, 0, 0);

    mod = 8'd8; step = 4'd2; up = 1'b0; sat = 1'b1; en = 1'b1;
    tick(); lit("sat_dn0", 1, 0, 2);
    tick(); lit("sat_dn1", 0, 1, 3);
    tick(); lit("sat_dn2", 0, 0, 3);
    sat = 1'b0;
    tick(); lit("sat_off", 0, 0, 0);
    tick(); lit("wrap_dn8", 6, 1, 2);

    mod = 8'd5; step = 4'd7; up = 1'b1;
    tick(); lit("oor_wrap", 0, 0, 1);
    tick(); lit("bigstep0", 2, 0, 1);
    tick(); lit("bigstep1", 4, 0, 1);
    tick(); lit("bigstep2", 1, 1, 1);
    up = 1'b0;
    tick(); lit("dir_flip", 4, 1, 2);
    mod = 8'd8; sat = 1'b1; up = 1'b1;
    tick(); lit("sat_jump", 7, 1, 3);
    en = 1'b0;
    tick(); lit("sat_idle", 7, 0, 0);

    load = 1'b1; lval = 8'd0; mod = 8'd10; step = 4'd3; up = 1'b1; sat = 1'b0;
    tick(); lit("load0", 0, 0, 0);
    load = 1'b0; en = 1'b1;
    tick(); lit("cnt3", 3, 0, 1);
    tick(); lit("cnt6", 6, 0, 1);
    #1 rst_n = 1'b0;
    #1 lit("async_rst", 0, 0, 0);
    #2 rst_n = 1'b1;
    tick(); lit("post_rst", 3, 0, 1);

    en = 1'b0; load = 1'b1; lval = 8'd255; mod = 8'd0; step = 4'd1; up = 1'b1; sat = 1'b0;
    tick(); lit("load255", 255, 0, 0);
    load = 1'b0; en = 1'b1;
    tick(); lit("full_wrap", 0, 1, 1);
    mod = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      lit($sformatf("m1_%0d", i), 0, 1, 1);
    end
    step = 4'd0;
    tick(); lit("m1_s0", 0, 0, 1);
    step = 4'd1; sat = 1'b1;
    tick(); lit("m1_sat", 0, 0, 3);

    en = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
